// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: valid/ready handshake, optional 2-entry skid,
// flush-to-bubble and a saturating stall counter.
module pipe_stage_buf #(
  parameter int unsigned   DW      = 96,
  parameter logic [DW-1:0] NOP_VAL = '0,
  parameter int unsigned   SKID    = 1,
  parameter int unsigned   CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    level,
  output logic [CW-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          in_xfer, out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign level     = state_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;

  // Skid build: ready is a flop of next state, so no combinational ready chain.
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = FULL1;
          end
        end
        FULL1: begin
          if (out_xfer && in_xfer) begin
            main_d = in_data;
          end else if (out_xfer) begin
            main_d  = NOP_VAL;
            state_d = EMPTY;
          end else if (in_xfer && (SKID != 0)) begin
            skid_d  = in_data;
            state_d = FULL2;
          end
        end
        FULL2: begin
          if (out_ready) begin
            main_d  = skid_q;
            skid_d  = NOP_VAL;
            state_d = FULL1;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

  always_comb begin
    in_ready_d  = (state_d != FULL2);
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= NOP_VAL;
      skid_q      <= NOP_VAL;
      stall_cnt_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      // Single-entry build pins the skid to a constant so it optimises away.
      skid_q      <= (SKID != 0) ? skid_d : NOP_VAL;
      stall_cnt_q <= stall_cnt_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a skid build with a 3-bit stall counter
// and a single-entry build with pass-through ready.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] NOP_A = 16'hBEEF;
  localparam logic [DW-1:0] NOP_B = 16'h00F0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_level;
  logic [2:0]    a_stall;

  logic          b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_level;
  logic [3:0]    b_stall;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pipe_stage_buf #(.DW(DW), .NOP_VAL(NOP_A), .SKID(1), .CW(3)) u_skid (
    .clk(clk), .reset(a_reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .level(a_level), .stall_cnt(a_stall)
  );

  pipe_stage_buf #(.DW(DW), .NOP_VAL(NOP_B), .SKID(0), .CW(4)) u_single (
    .clk(clk), .reset(b_reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .level(b_level), .stall_cnt(b_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h1234; a_out_ready = 1'b0;
    b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0;      b_out_ready = 1'b0;

    // Reset with a valid input present
    tick();
    check("rst_valid", a_out_valid, 0);
    check("rst_data", a_out_data, NOP_A);
    check("rst_level", a_level, 0);
    check("rst_ready", a_in_ready, 1);
    check("rst_stall", a_stall, 0);
    check("rst_b_data", b_out_data, NOP_B);
    a_reset = 1'b0; b_reset = 1'b0; a_in_valid = 1'b0;
    tick();
    check("rst_hold_valid", a_out_valid, 0);

    // Full-throughput stream
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1; a_in_data = DW'(i);
      #1 check("strm_ready", a_in_ready, 1);
      tick();
      check("strm_data", a_out_data, i);
      check("strm_valid", a_out_valid, 1);
      check("strm_level", a_level, 1);
    end
    a_in_valid = 1'b0;
    tick();
    check("strm_drain_valid", a_out_valid, 0);
    check("strm_drain_data", a_out_data, NOP_A);
    check("strm_stall", a_stall, 0);

    // Backpressure into the skid
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h000A;
    tick();
    check("bp_lvl1", a_level, 1);
    check("bp_ready1", a_in_ready, 1);
    a_in_data = 16'h000B;
    tick();
    check("bp_lvl2", a_level, 2);
    check("bp_ready2", a_in_ready, 0);
    check("bp_data_a", a_out_data, 16'h000A);
    a_in_data = 16'h000C;
    tick();
    check("bp_hold_lvl", a_level, 2);
    check("bp_hold_data", a_out_data, 16'h000A);
    check("bp_stall", a_stall, 2);
    a_out_ready = 1'b1;
    tick();
    check("rel_data_b", a_out_data, 16'h000B);
    check("rel_lvl", a_level, 1);
    check("rel_ready", a_in_ready, 1);
    tick();
    check("rel_data_c", a_out_data, 16'h000C);
    a_in_valid = 1'b0;
    tick();
    check("rel_empty", a_out_valid, 0);
    check("rel_stall", a_stall, 2);

    // Flush while FULL2
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h0011;
    tick();
    a_in_data = 16'h0022;
    tick();
    check("fl_pre_lvl", a_level, 2);
    a_flush = 1'b1; a_in_data = 16'h000D;
    tick();
    check("fl_lvl", a_level, 0);
    check("fl_valid", a_out_valid, 0);
    check("fl_data", a_out_data, NOP_A);
    check("fl_ready", a_in_ready, 1);
    check("fl_stall", a_stall, 4);
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_d", a_out_valid, 0);
    end

    // Stall counter saturation at 2^3-1
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0; a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h0055;
    tick();
    a_in_valid = 1'b0;
    check("sat_start", a_stall, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) check("sat_3", a_stall, 3);
      if (i == 7) check("sat_7", a_stall, 7);
    end
    check("sat_10", a_stall, 7);
    check("sat_data", a_out_data, 16'h0055);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("sat_flush", a_stall, 7);
    check("sat_flush_lvl", a_level, 0);
    tick();
    check("sat_after", a_stall, 7);

    // Single-entry build: pass-through ready
    b_in_valid = 1'b1; b_in_data = 16'h0061; b_out_ready = 1'b0;
    #1 check("s0_ready_empty", b_in_ready, 1);
    tick();
    check("s0_data1", b_out_data, 16'h0061);
    check("s0_lvl1", b_level, 1);
    b_in_data = 16'h0062;
    #1 check("s0_ready_blocked", b_in_ready, 0);
    tick();
    check("s0_hold", b_out_data, 16'h0061);
    check("s0_hold_lvl", b_level, 1);
    check("s0_stall", b_stall, 1);
    b_out_ready = 1'b1;
    #1 check("s0_ready_comb", b_in_ready, 1);
    tick();
    check("s0_replace", b_out_data, 16'h0062);
    check("s0_replace_lvl", b_level, 1);
    b_in_valid = 1'b0;
    tick();
    check("s0_empty", b_out_valid, 0);
    check("s0_nop", b_out_data, NOP_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
